// File: rtl/pcie_controller.sv
// pcie_controller: host-side loader standing in for the PCIe link.
// Streams the input feature map into the layer RAM and services single-word
// weight and bias write requests with synthetic data. Three independent FSMs
// share one clock and one synchronous reset.
module pcie_controller #(
  parameter int LAYER_WORDS = 77294
) (
  input  logic          clk,
  input  logic          pcieRst,
  input  logic          pcieLayerCmd,
  input  logic [3:0]    runLayer,
  input  logic          updateBias,
  input  logic          updateBiasAddr,
  input  logic          updateWeight,
  input  logic [9:0]    updateWeightAddr,
  output logic          updateBiasDone,
  output logic          updateWeightDone,
  output logic          pcieDataReady,
  output logic          connnectPC,
  output logic          layerWriteEn,
  output logic [31:0]   writeLayerData,
  output logic [17:0]   layerDataAddr,
  output logic          weightWriteEn,
  output logic [1935:0] writeWeightData,
  output logic [9:0]    weightDataAddr,
  output logic          biasWriteEn,
  output logic [15:0]   writeBiasData,
  output logic          biasDataAddr,
  output logic          wea
);

  localparam logic [3:0]  LAYER_IDLE  = 4'd0;
  localparam logic [3:0]  LAYER_CONV1 = 4'd1;
  localparam logic [3:0]  LAYER_CONV2 = 4'd3;
  localparam logic [3:0]  LAYER_CONV3 = 4'd5;
  localparam logic [3:0]  LAYER_CONV4 = 4'd6;
  localparam logic [3:0]  LAYER_CONV5 = 4'd7;
  localparam logic [17:0] LAST_ADDR   = 18'(LAYER_WORDS - 1);

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE}   layerState_t;
  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DONE}  weightState_t;
  typedef enum logic [1:0] {B_IDLE, B_WRITE, B_DONE}  biasState_t;

  layerState_t  layerState;
  weightState_t weightState;
  biasState_t   biasState;

  logic [17:0]   nextLayerAddr;
  logic [15:0]   weightElem;
  int            kernelSize;
  logic [1935:0] nextWeightWord;

  assign nextLayerAddr = layerDataAddr + 18'd1;
  assign weightElem    = {runLayer, updateWeightAddr, 2'b00};

  // Build the synthetic weight word for the current request: the first
  // kernelSize elements carry the layer/address tag, the rest stay zero.
  always_comb begin
    kernelSize = 0;
    case (runLayer)
      LAYER_CONV1: kernelSize = 121;
      LAYER_CONV2: kernelSize = 25;
      LAYER_CONV3, LAYER_CONV4, LAYER_CONV5: kernelSize = 9;
      default: kernelSize = 0;
    endcase
    nextWeightWord = '0;
    for (int k = 0; k < 121; k++) begin
      if (k < kernelSize) begin
        nextWeightWord[16*k +: 16] = weightElem;
      end
    end
  end

  // Layer load FSM: one feature-map word per cycle, then hold ready until
  // the command drops; dropping the command mid-load abandons the load.
  always_ff @(posedge clk) begin
    if (pcieRst) begin
      layerState     <= L_IDLE;
      layerWriteEn   <= 1'b0;
      connnectPC     <= 1'b0;
      pcieDataReady  <= 1'b0;
      layerDataAddr  <= '0;
      writeLayerData <= '0;
    end else begin
      case (layerState)
        L_IDLE: begin
          if (pcieLayerCmd && runLayer == LAYER_IDLE) begin
            layerState     <= L_LOAD;
            layerWriteEn   <= 1'b1;
            connnectPC     <= 1'b1;
            layerDataAddr  <= '0;
            writeLayerData <= '0;
          end
        end
        L_LOAD: begin
          if (!pcieLayerCmd) begin
            layerState     <= L_IDLE;
            layerWriteEn   <= 1'b0;
            connnectPC     <= 1'b0;
            layerDataAddr  <= '0;
            writeLayerData <= '0;
          end else if (layerDataAddr == LAST_ADDR) begin
            layerState     <= L_DONE;
            layerWriteEn   <= 1'b0;
            connnectPC     <= 1'b0;
            pcieDataReady  <= 1'b1;
            layerDataAddr  <= '0;
            writeLayerData <= '0;
          end else begin
            layerDataAddr  <= nextLayerAddr;
            writeLayerData <= {nextLayerAddr[15:0], nextLayerAddr[15:0]};
          end
        end
        L_DONE: begin
          if (!pcieLayerCmd) begin
            layerState    <= L_IDLE;
            pcieDataReady <= 1'b0;
          end
        end
        default: layerState <= L_IDLE;
      endcase
    end
  end

  // Weight update FSM: capture request, write for one cycle, hold done
  // until the requester lets go.
  always_ff @(posedge clk) begin
    if (pcieRst) begin
      weightState      <= W_IDLE;
      weightWriteEn    <= 1'b0;
      updateWeightDone <= 1'b0;
      weightDataAddr   <= '0;
      writeWeightData  <= '0;
    end else begin
      case (weightState)
        W_IDLE: begin
          if (updateWeight) begin
            weightState     <= W_WRITE;
            weightWriteEn   <= 1'b1;
            weightDataAddr  <= updateWeightAddr;
            writeWeightData <= nextWeightWord;
          end
        end
        W_WRITE: begin
          weightState      <= W_DONE;
          weightWriteEn    <= 1'b0;
          updateWeightDone <= 1'b1;
        end
        W_DONE: begin
          if (!updateWeight) begin
            weightState      <= W_IDLE;
            updateWeightDone <= 1'b0;
          end
        end
        default: weightState <= W_IDLE;
      endcase
    end
  end

  // Bias update FSM: same handshake as the weight side, 16-bit tagged word.
  always_ff @(posedge clk) begin
    if (pcieRst) begin
      biasState      <= B_IDLE;
      biasWriteEn    <= 1'b0;
      updateBiasDone <= 1'b0;
      biasDataAddr   <= 1'b0;
      writeBiasData  <= '0;
    end else begin
      case (biasState)
        B_IDLE: begin
          if (updateBias) begin
            biasState     <= B_WRITE;
            biasWriteEn   <= 1'b1;
            biasDataAddr  <= updateBiasAddr;
            writeBiasData <= {runLayer, 11'b0, updateBiasAddr};
          end
        end
        B_WRITE: begin
          biasState      <= B_DONE;
          biasWriteEn    <= 1'b0;
          updateBiasDone <= 1'b1;
        end
        B_DONE: begin
          if (!updateBias) begin
            biasState      <= B_IDLE;
            updateBiasDone <= 1'b0;
          end
        end
        default: biasState <= B_IDLE;
      endcase
    end
  end

  assign wea = layerWriteEn | weightWriteEn | biasWriteEn;

endmodule

// File: tb/tb_pcie_controller.sv
// Testbench for pcie_controller: stimulus pushes expected writes into
// scoreboard queues, a negedge monitor pops and compares against a
// behavioural model of the feature-map stream and the weight/bias words.
module tb_pcie_controller;

  localparam int LAYER_WORDS = 77294;

  logic          clk = 1'b0;
  logic          pcieRst;
  logic          pcieLayerCmd;
  logic [3:0]    runLayer;
  logic          updateBias;
  logic          updateBiasAddr;
  logic          updateWeight;
  logic [9:0]    updateWeightAddr;
  logic          updateBiasDone;
  logic          updateWeightDone;
  logic          pcieDataReady;
  logic          connnectPC;
  logic          layerWriteEn;
  logic [31:0]   writeLayerData;
  logic [17:0]   layerDataAddr;
  logic          weightWriteEn;
  logic [1935:0] writeWeightData;
  logic [9:0]    weightDataAddr;
  logic          biasWriteEn;
  logic [15:0]   writeBiasData;
  logic          biasDataAddr;
  logic          wea;

  pcie_controller #(.LAYER_WORDS(LAYER_WORDS)) dut (
    .clk(clk), .pcieRst(pcieRst), .pcieLayerCmd(pcieLayerCmd), .runLayer(runLayer),
    .updateBias(updateBias), .updateBiasAddr(updateBiasAddr),
    .updateWeight(updateWeight), .updateWeightAddr(updateWeightAddr),
    .updateBiasDone(updateBiasDone), .updateWeightDone(updateWeightDone),
    .pcieDataReady(pcieDataReady), .connnectPC(connnectPC),
    .layerWriteEn(layerWriteEn), .writeLayerData(writeLayerData), .layerDataAddr(layerDataAddr),
    .weightWriteEn(weightWriteEn), .writeWeightData(writeWeightData), .weightDataAddr(weightDataAddr),
    .biasWriteEn(biasWriteEn), .writeBiasData(writeBiasData), .biasDataAddr(biasDataAddr),
    .wea(wea)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct {int addr; int layer;} req_t;
  typedef struct {int len; bit ready;} run_t;

  req_t weightQ[$];
  req_t biasQ[$];
  run_t runQ[$];
  int   total = 0;
  int   bad = 0;
  bit   monOn = 1'b0;
  int   runLen = 0;
  bit   prevEn = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int kernelSize(input int layer);
    case (layer)
      1: return 121;
      3: return 25;
      5, 6, 7: return 9;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1935:0] weightModel(input int addr, input int layer);
    logic [1935:0] w;
    logic [15:0]   v;
    w = '0;
    v = 16'(layer * 4096 + addr * 4);
    for (int k = 0; k < 121; k++)
      if (k < kernelSize(layer)) w[16*k +: 16] = v;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushRun(input int len, input bit ready);
    run_t r;
    r.len = len;
    r.ready = ready;
    runQ.push_back(r);
  endtask

  task automatic applyStimulus(input bit doW, input int wAddr, input bit doB, input int bAddr, input int layer);
    req_t r;
    runLayer = 4'(layer);
    r.layer = layer;
    if (doW) begin
      updateWeight = 1'b1;
      updateWeightAddr = 10'(wAddr);
      r.addr = wAddr;
      weightQ.push_back(r);
    end
    if (doB) begin
      updateBias = 1'b1;
      updateBiasAddr = 1'(bAddr);
      r.addr = bAddr;
      biasQ.push_back(r);
    end
  endtask

  // Monitor: compares every observed write against the scoreboard queues
  // and the expected feature-map address sequence.
  always @(negedge clk) begin
    if (monOn) begin
      logic [31:0] expData;
      checkOutput("wea", wea, layerWriteEn | weightWriteEn | biasWriteEn);
      checkOutput("connnectPC", connnectPC, layerWriteEn);
      if (layerWriteEn === 1'b1) begin
        expData = {runLen[15:0], runLen[15:0]};
        checkOutput("layerAddr", layerDataAddr, runLen);
        checkOutput("layerData", writeLayerData, expData);
        runLen++;
      end else if (prevEn) begin
        if (runQ.size() == 0) begin
          checkOutput("layerRunUnexpected", runLen, 0);
        end else begin
          run_t r;
          r = runQ.pop_front();
          checkOutput("layerRunLen", runLen, r.len);
          checkOutput("layerRunReady", pcieDataReady, r.ready);
        end
        runLen = 0;
      end
      prevEn = (layerWriteEn === 1'b1);
      if (weightWriteEn === 1'b1) begin
        if (weightQ.size() == 0) begin
          checkOutput("weightUnexpected", weightWriteEn, 0);
        end else begin
          req_t r;
          logic [1935:0] expW;
          r = weightQ.pop_front();
          expW = weightModel(r.addr, r.layer);
          checkOutput("weightAddr", weightDataAddr, r.addr);
          total++;
          if (writeWeightData !== expW) begin
            bad++;
            $display("[TB] FAIL weightData: addr %0d layer %0d got e0=%h e120=%h expected e0=%h e120=%h",
                     r.addr, r.layer, writeWeightData[15:0], writeWeightData[1935:1920],
                     expW[15:0], expW[1935:1920]);
          end
        end
      end
      if (biasWriteEn === 1'b1) begin
        if (biasQ.size() == 0) begin
          checkOutput("biasUnexpected", biasWriteEn, 0);
        end else begin
          req_t r;
          r = biasQ.pop_front();
          checkOutput("biasAddr", biasDataAddr, r.addr);
          checkOutput("biasData", writeBiasData, 64'(r.layer * 4096 + r.addr));
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int guard;
    pcieRst = 1'b1;
    pcieLayerCmd = 1'b0;
    runLayer = 4'd0;
    updateBias = 1'b0;
    updateBiasAddr = 1'b0;
    updateWeight = 1'b0;
    updateWeightAddr = '0;

    tick(1);
    checkOutput("rstLayerEn", layerWriteEn, 0);
    checkOutput("rstLayerData", writeLayerData, 0);
    checkOutput("rstLayerAddr", layerDataAddr, 0);
    checkOutput("rstWeightEn", weightWriteEn, 0);
    checkOutput("rstWeightData", {63'd0, |writeWeightData}, 0);
    checkOutput("rstWeightAddr", weightDataAddr, 0);
    checkOutput("rstBiasEn", biasWriteEn, 0);
    checkOutput("rstBiasData", writeBiasData, 0);
    checkOutput("rstBiasAddr", biasDataAddr, 0);
    checkOutput("rstWeightDone", updateWeightDone, 0);
    checkOutput("rstBiasDone", updateBiasDone, 0);
    checkOutput("rstReady", pcieDataReady, 0);
    checkOutput("rstConnect", connnectPC, 0);
    checkOutput("rstWea", wea, 0);
    pcieRst = 1'b0;
    monOn = 1'b1;

    // Reset in the middle of a load, then restart, then abort by command.
    pushRun(40, 1'b0);
    pushRun(20, 1'b0);
    pcieLayerCmd = 1'b1;
    tick(40);
    pcieRst = 1'b1;
    tick(1);
    checkOutput("midRstEn", layerWriteEn, 0);
    checkOutput("midRstReady", pcieDataReady, 0);
    pcieRst = 1'b0;
    tick(1);
    checkOutput("restartEn", layerWriteEn, 1);
    checkOutput("restartAddr", layerDataAddr, 0);
    tick(19);
    pcieLayerCmd = 1'b0;
    tick(1);
    checkOutput("abortEn", layerWriteEn, 0);
    checkOutput("abortReady", pcieDataReady, 0);
    tick(2);

    // Full load with concurrent weight/bias traffic.
    pushRun(LAYER_WORDS, 1'b1);
    pcieLayerCmd = 1'b1;
    runLayer = 4'd0;
    tick(1);
    checkOutput("loadAddr0", layerDataAddr, 0);
    tick(5);
    checkOutput("loadWord5", writeLayerData, 32'h0005_0005);
    tick(5);
    applyStimulus(1'b1, 3, 1'b1, 1, 1);
    tick(1);
    checkOutput("c11WeightEn", weightWriteEn, 1);
    checkOutput("c11WeightAddr", weightDataAddr, 3);
    checkOutput("c11Elem0", writeWeightData[15:0], 16'h100C);
    checkOutput("c11Elem120", writeWeightData[1935:1920], 16'h100C);
    checkOutput("c11BiasEn", biasWriteEn, 1);
    checkOutput("c11BiasData", writeBiasData, 16'h1001);
    tick(1);
    checkOutput("c12WeightDone", updateWeightDone, 1);
    checkOutput("c12BiasDone", updateBiasDone, 1);
    checkOutput("c12WeightEn", weightWriteEn, 0);
    tick(1);
    updateBias = 1'b0;
    tick(1);
    checkOutput("c14BiasDone", updateBiasDone, 0);
    checkOutput("c14WeightDone", updateWeightDone, 1);
    tick(1);
    updateWeight = 1'b0;
    tick(1);
    checkOutput("c16WeightDone", updateWeightDone, 0);
    applyStimulus(1'b1, 0, 1'b0, 0, 1);
    tick(1);
    checkOutput("c17WeightEn", weightWriteEn, 1);
    checkOutput("c17Elem0", writeWeightData[15:0], 16'h1000);
    tick(1);
    checkOutput("c18WeightDone", updateWeightDone, 1);
    updateWeight = 1'b0;
    tick(1);
    applyStimulus(1'b1, 7, 1'b0, 0, 5);
    tick(1);
    checkOutput("conv3Elem8", writeWeightData[143:128], 16'h501C);
    checkOutput("conv3Elem9", writeWeightData[159:144], 16'h0000);
    tick(1);
    updateWeight = 1'b0;
    tick(1);
    applyStimulus(1'b1, 1023, 1'b1, 0, 9);
    tick(2);
    checkOutput("fc6WeightDone", updateWeightDone, 1);
    checkOutput("fc6BiasDone", updateBiasDone, 1);
    updateWeight = 1'b0;
    updateBias = 1'b0;
    tick(1);

    guard = 0;
    while (pcieDataReady !== 1'b1 && guard < 80000) begin
      tick(1);
      guard++;
    end
    checkOutput("loadReady", pcieDataReady, 1);
    checkOutput("loadConnectLow", connnectPC, 0);
    tick(3);
    checkOutput("readyHeld", pcieDataReady, 1);
    checkOutput("noReload", layerWriteEn, 0);
    pcieLayerCmd = 1'b0;
    tick(1);
    checkOutput("readyCleared", pcieDataReady, 0);

    // Randomized weight/bias handshakes.
    for (int i = 0; i < 30; i++) begin
      bit doW, doB;
      int hold;
      doW = 1'($urandom_range(0, 1));
      doB = 1'($urandom_range(0, 1));
      if (!doW && !doB) doW = 1'b1;
      applyStimulus(doW, $urandom_range(0, 1023), doB, $urandom_range(0, 1), $urandom_range(0, 15));
      tick(1);
      runLayer = 4'($urandom_range(0, 15));
      checkOutput("rndWeightEn", weightWriteEn, doW);
      checkOutput("rndBiasEn", biasWriteEn, doB);
      tick(1);
      checkOutput("rndWeightDone", updateWeightDone, doW);
      checkOutput("rndBiasDone", updateBiasDone, doB);
      hold = $urandom_range(0, 3);
      if (hold > 0) tick(hold);
      checkOutput("rndWeightHold", updateWeightDone, doW);
      checkOutput("rndBiasHold", updateBiasDone, doB);
      updateWeight = 1'b0;
      updateBias = 1'b0;
      tick(1);
      checkOutput("rndWeightClr", updateWeightDone, 0);
      checkOutput("rndBiasClr", updateBiasDone, 0);
    end

    tick(2);
    checkOutput("weightQEmpty", weightQ.size(), 0);
    checkOutput("biasQEmpty", biasQ.size(), 0);
    checkOutput("runQEmpty", runQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
